// File: rtl/synth_pkg.sv
// Shared constants, state encoding and register-image helpers for the synth_regs SPI register bank.
package synth_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CMD  = 2'd1,
    DATA = 2'd2,
    DONE = 2'd3
  } state_t;

  localparam logic [6:0] ADDR_CTRL    = 7'h00;
  localparam logic [6:0] ADDR_ADSR_AI = 7'h01;
  localparam logic [6:0] ADDR_ADSR_DI = 7'h02;
  localparam logic [6:0] ADDR_ADSR_S  = 7'h03;
  localparam logic [6:0] ADDR_ADSR_RI = 7'h04;
  localparam logic [6:0] ADDR_OSC0    = 7'h05;
  localparam logic [6:0] ADDR_OSC1    = 7'h06;
  localparam logic [6:0] ADDR_OSC2    = 7'h07;
  localparam logic [6:0] ADDR_OSC3    = 7'h08;
  localparam logic [6:0] ADDR_FA_LO   = 7'h09;
  localparam logic [6:0] ADDR_FA_HI   = 7'h0A;
  localparam logic [6:0] ADDR_FB_LO   = 7'h0B;
  localparam logic [6:0] ADDR_FB_HI   = 7'h0C;
  localparam logic [6:0] ADDR_ID      = 7'h7F;

  localparam logic [7:0]  RST_CTRL     = 8'h00;
  localparam logic [7:0]  RST_ADSR_AI  = 8'h08;
  localparam logic [7:0]  RST_ADSR_DI  = 8'h08;
  localparam logic [7:0]  RST_ADSR_S   = 8'h80;
  localparam logic [7:0]  RST_ADSR_RI  = 8'h08;
  localparam logic [31:0] RST_OSC      = 32'h0000_005A;
  localparam logic [15:0] RST_FILTER_A = 16'h4000;
  localparam logic [15:0] RST_FILTER_B = 16'h4000;
  localparam logic [7:0]  ID_VALUE     = 8'hCD;

  typedef struct packed {
    logic        trig;
    logic [7:0]  adsr_ai;
    logic [7:0]  adsr_di;
    logic [7:0]  adsr_s;
    logic [7:0]  adsr_ri;
    logic [31:0] osc_count;
    logic [15:0] filter_a;
    logic [15:0] filter_b;
  } cfg_t;

  localparam cfg_t CFG_RESET = '{
    trig:      RST_CTRL[0],
    adsr_ai:   RST_ADSR_AI,
    adsr_di:   RST_ADSR_DI,
    adsr_s:    RST_ADSR_S,
    adsr_ri:   RST_ADSR_RI,
    osc_count: RST_OSC,
    filter_a:  RST_FILTER_A,
    filter_b:  RST_FILTER_B
  };

  // Multi-byte fields read back their committed value, never the staging shadow.
  function automatic logic [7:0] read_byte(input cfg_t c, input logic [6:0] a);
    logic [7:0] r;
    r = 8'h00;
    case (a)
      ADDR_CTRL:    r = {7'b0, c.trig};
      ADDR_ADSR_AI: r = c.adsr_ai;
      ADDR_ADSR_DI: r = c.adsr_di;
      ADDR_ADSR_S:  r = c.adsr_s;
      ADDR_ADSR_RI: r = c.adsr_ri;
      ADDR_OSC0:    r = c.osc_count[7:0];
      ADDR_OSC1:    r = c.osc_count[15:8];
      ADDR_OSC2:    r = c.osc_count[23:16];
      ADDR_OSC3:    r = c.osc_count[31:24];
      ADDR_FA_LO:   r = c.filter_a[7:0];
      ADDR_FA_HI:   r = c.filter_a[15:8];
      ADDR_FB_LO:   r = c.filter_b[7:0];
      ADDR_FB_HI:   r = c.filter_b[15:8];
      ADDR_ID:      r = ID_VALUE;
      default:      r = 8'h00;
    endcase
    return r;
  endfunction

endpackage

// File: rtl/synth_regs_sync2.sv
// Two-flop synchronizer with asynchronous active-low reset and a selectable reset level.
module sync2 #(
  parameter logic RESET_VAL = 1'b0
) (
  input  logic clk,
  input  logic rst_n,
  input  logic d,
  output logic q
);

  logic meta;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      meta <= RESET_VAL;
      q    <= RESET_VAL;
    end else begin
      meta <= d;
      q    <= meta;
    end
  end

endmodule

// File: rtl/synth_regs.sv
// SPI-slave (mode 0) configuration register bank feeding synth; multi-byte fields commit atomically.
// Build option: define SYNTH_REGS_READBACK_EN to build the read shifter and drive register data on miso.
module synth_regs
  import synth_pkg::*;
(
  input  logic        clk,
  input  logic        rst_n,
  input  logic        sclk,
  input  logic        cs_n,
  input  logic        mosi,
  output logic        miso,
  output logic        trig,
  output logic [7:0]  adsr_ai,
  output logic [7:0]  adsr_di,
  output logic [7:0]  adsr_s,
  output logic [7:0]  adsr_ri,
  output logic [31:0] osc_count,
  output logic [15:0] filter_a,
  output logic [15:0] filter_b
);

  logic sclk_s;
  logic cs_s;
  logic mosi_s;

  sync2 #(.RESET_VAL(1'b0)) u_sync_sclk (
    .clk   (clk),
    .rst_n (rst_n),
    .d     (sclk),
    .q     (sclk_s)
  );

  // Resetting chip-select low means a frame already running at reset release never shows a falling edge.
  sync2 #(.RESET_VAL(1'b0)) u_sync_cs (
    .clk   (clk),
    .rst_n (rst_n),
    .d     (cs_n),
    .q     (cs_s)
  );

  sync2 #(.RESET_VAL(1'b0)) u_sync_mosi (
    .clk   (clk),
    .rst_n (rst_n),
    .d     (mosi),
    .q     (mosi_s)
  );

  logic sclk_d;
  logic cs_d;
  logic sclk_rise;
  logic mosi_q;
  logic cs_fall;
  logic cs_rise;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sclk_d    <= 1'b0;
      cs_d      <= 1'b0;
      sclk_rise <= 1'b0;
      mosi_q    <= 1'b0;
    end else begin
      sclk_d    <= sclk_s;
      cs_d      <= cs_s;
      sclk_rise <= sclk_s & ~sclk_d;
      mosi_q    <= mosi_s;
    end
  end

  assign cs_fall = cs_d & ~cs_s;
  assign cs_rise = cs_s & ~cs_d;

  state_t     state;
  state_t     state_nxt;
  logic [2:0] bit_cnt;
  logic [7:0] shreg;
  logic       rw;
  logic [6:0] addr;
  logic       last_bit;

  assign last_bit = sclk_rise & (bit_cnt == 3'd7);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    if (cs_rise) begin
      state_nxt = IDLE;
    end else begin
      case (state)
        IDLE:    if (cs_fall) state_nxt = CMD;
        CMD:     if (last_bit) state_nxt = DATA;
        DATA:    if (last_bit) state_nxt = DONE;
        default: state_nxt = state;
      endcase
    end
  end

  // The 3-bit counter wraps to zero on the eighth bit, so DATA starts counting afresh.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      bit_cnt <= 3'd0;
      shreg   <= 8'h00;
      rw      <= 1'b0;
      addr    <= 7'h00;
    end else if (state == IDLE) begin
      bit_cnt <= 3'd0;
    end else if (((state == CMD) || (state == DATA)) && sclk_rise) begin
      shreg   <= {shreg[6:0], mosi_q};
      bit_cnt <= bit_cnt + 3'd1;
      if ((state == CMD) && (bit_cnt == 3'd7)) begin
        rw   <= shreg[6];
        addr <= {shreg[5:0], mosi_q};
      end
    end
  end

  logic       wr_en;
  logic [7:0] wr_data;

  assign wr_en   = (state == DATA) & last_bit & ~rw;
  assign wr_data = {shreg[6:0], mosi_q};

  cfg_t        cfg;
  logic [23:0] osc_shadow;
  logic [7:0]  fa_shadow;
  logic [7:0]  fb_shadow;

  // Lower bytes of wide fields only stage; the top byte commits shadow and byte together.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cfg        <= CFG_RESET;
      osc_shadow <= RST_OSC[23:0];
      fa_shadow  <= RST_FILTER_A[7:0];
      fb_shadow  <= RST_FILTER_B[7:0];
    end else if (wr_en) begin
      case (addr)
        ADDR_CTRL:    cfg.trig    <= wr_data[0];
        ADDR_ADSR_AI: cfg.adsr_ai <= wr_data;
        ADDR_ADSR_DI: cfg.adsr_di <= wr_data;
        ADDR_ADSR_S:  cfg.adsr_s  <= wr_data;
        ADDR_ADSR_RI: cfg.adsr_ri <= wr_data;
        ADDR_OSC0:    osc_shadow[7:0]   <= wr_data;
        ADDR_OSC1:    osc_shadow[15:8]  <= wr_data;
        ADDR_OSC2:    osc_shadow[23:16] <= wr_data;
        ADDR_OSC3:    cfg.osc_count     <= {wr_data, osc_shadow};
        ADDR_FA_LO:   fa_shadow         <= wr_data;
        ADDR_FA_HI:   cfg.filter_a      <= {wr_data, fa_shadow};
        ADDR_FB_LO:   fb_shadow         <= wr_data;
        ADDR_FB_HI:   cfg.filter_b      <= {wr_data, fb_shadow};
        default:      cfg <= cfg;
      endcase
    end
  end

  assign trig      = cfg.trig;
  assign adsr_ai   = cfg.adsr_ai;
  assign adsr_di   = cfg.adsr_di;
  assign adsr_s    = cfg.adsr_s;
  assign adsr_ri   = cfg.adsr_ri;
  assign osc_count = cfg.osc_count;
  assign filter_a  = cfg.filter_a;
  assign filter_b  = cfg.filter_b;

`ifdef SYNTH_REGS_READBACK_EN
  logic       sclk_fall;
  logic [7:0] rd_shift;
  logic [7:0] rd_byte;
  logic       load_read;
  logic       miso_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) sclk_fall <= 1'b0;
    else        sclk_fall <= ~sclk_s & sclk_d;
  end

  assign rd_byte   = read_byte(cfg, {shreg[5:0], mosi_q});
  assign load_read = (state == CMD) & last_bit & shreg[6] & ~cs_rise;

  // The falling edge before the first DATA rise is skipped so bit7 stays on the line for that sample.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rd_shift <= 8'h00;
      miso_q   <= 1'b0;
    end else if (load_read) begin
      rd_shift <= rd_byte;
      miso_q   <= rd_byte[7];
    end else if ((state == DATA) && (state_nxt == DATA) && rw) begin
      if (sclk_fall && (bit_cnt != 3'd0)) begin
        rd_shift <= {rd_shift[6:0], 1'b0};
        miso_q   <= rd_shift[6];
      end
    end else begin
      miso_q <= 1'b0;
    end
  end

  assign miso = miso_q;
`else
  assign miso = 1'b0;
`endif

endmodule

// File: tb/tb_synth_regs.sv
// Randomized and directed SPI-frame bench for synth_regs against a byte-level register model.
module tb_synth_regs;

  logic        clk;
  logic        rst_n;
  logic        sclk;
  logic        cs_n;
  logic        mosi;
  logic        miso;
  logic        trig;
  logic [7:0]  adsr_ai;
  logic [7:0]  adsr_di;
  logic [7:0]  adsr_s;
  logic [7:0]  adsr_ri;
  logic [31:0] osc_count;
  logic [15:0] filter_a;
  logic [15:0] filter_b;

  int assert_count = 0;
  int fail_count   = 0;

`ifdef SYNTH_REGS_READBACK_EN
  localparam bit READBACK = 1'b1;
`else
  localparam bit READBACK = 1'b0;
`endif

  synth_regs dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .sclk      (sclk),
    .cs_n      (cs_n),
    .mosi      (mosi),
    .miso      (miso),
    .trig      (trig),
    .adsr_ai   (adsr_ai),
    .adsr_di   (adsr_di),
    .adsr_s    (adsr_s),
    .adsr_ri   (adsr_ri),
    .osc_count (osc_count),
    .filter_a  (filter_a),
    .filter_b  (filter_b)
  );

  initial clk = 1'b0;
  always #24 clk = ~clk;

  initial begin
    #4000000;
    $display("[TB] FAIL watchdog: simulation did not complete in time");
    $fatal(1, "[TB] watchdog expired");
  end

  // Reference model: bytes as last written per address, plus the values synth should currently see.
  logic [7:0]  staged [0:12];
  logic        m_trig;
  logic [7:0]  m_ai, m_di, m_s, m_ri;
  logic [31:0] m_osc;
  logic [15:0] m_fa, m_fb;

  function automatic void model_reset();
    m_trig = 1'b0;
    m_ai = 8'h08; m_di = 8'h08; m_s = 8'h80; m_ri = 8'h08;
    m_osc = 32'h0000_005A;
    m_fa = 16'h4000;
    m_fb = 16'h4000;
    for (int i = 0; i <= 12; i++) staged[i] = 8'h00;
    staged[5]  = 8'h5A;
    staged[10] = 8'h40;
    staged[12] = 8'h40;
  endfunction

  function automatic void model_write(input int a, input logic [7:0] d);
    if (a <= 12) staged[a] = d;
    case (a)
      0:  m_trig = d[0];
      1:  m_ai = d;
      2:  m_di = d;
      3:  m_s  = d;
      4:  m_ri = d;
      8:  m_osc = 32'(staged[5]) + (32'(staged[6]) << 8) + (32'(staged[7]) << 16) + (32'(staged[8]) << 24);
      10: m_fa = 16'(staged[9]) + (16'(staged[10]) << 8);
      12: m_fb = 16'(staged[11]) + (16'(staged[12]) << 8);
      default: ;
    endcase
  endfunction

  function automatic logic [7:0] model_read(input int a);
    if (a == 0) return {7'b0, m_trig};
    if (a == 1) return m_ai;
    if (a == 2) return m_di;
    if (a == 3) return m_s;
    if (a == 4) return m_ri;
    if (a >= 5 && a <= 8) return 8'(m_osc >> (8 * (a - 5)));
    if (a == 9 || a == 10) return 8'(m_fa >> (8 * (a - 9)));
    if (a == 11 || a == 12) return 8'(m_fb >> (8 * (a - 11)));
    if (a == 127) return 8'hCD;
    return 8'h00;
  endfunction

  task automatic wait_clks(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    assert_count++;
    assert (observed === expected) else begin
      fail_count++;
      $error("[TB] FAIL %s: observed %h, expected %h", tag, observed, expected);
    end
  endtask

  task automatic checkAll(input string tag);
    checkOutput({tag, ".trig"},      32'(trig),      32'(m_trig));
    checkOutput({tag, ".adsr_ai"},   32'(adsr_ai),   32'(m_ai));
    checkOutput({tag, ".adsr_di"},   32'(adsr_di),   32'(m_di));
    checkOutput({tag, ".adsr_s"},    32'(adsr_s),    32'(m_s));
    checkOutput({tag, ".adsr_ri"},   32'(adsr_ri),   32'(m_ri));
    checkOutput({tag, ".osc_count"}, osc_count,      m_osc);
    checkOutput({tag, ".filter_a"},  32'(filter_a),  32'(m_fa));
    checkOutput({tag, ".filter_b"},  32'(filter_b),  32'(m_fb));
    checkOutput({tag, ".miso"},      32'(miso),      32'(0));
  endtask

  // Drives bits [first..last] of a frame, four clk per sclk phase; returns just after the last rising edge.
  task automatic shiftBits(input logic [15:0] frame, input int first, input int last, inout logic [7:0] rd);
    for (int i = first; i <= last; i++) begin
      sclk = 1'b0;
      mosi = frame[15 - i];
      wait_clks(4);
      if (i >= 8) rd = {rd[6:0], miso};
      sclk = 1'b1;
      if (i != last) wait_clks(4);
    end
  endtask

  task automatic applyStimulus(input logic [15:0] frame, input int nbits, output logic [7:0] rd);
    logic [7:0] acc;
    acc = 8'h00;
    cs_n = 1'b0;
    wait_clks(6);
    shiftBits(frame, 0, nbits - 1, acc);
    rd = acc;
  endtask

  task automatic endFrame();
    wait_clks(6);
    sclk = 1'b0;
    wait_clks(2);
    cs_n = 1'b1;
    wait_clks(6);
  endtask

  task automatic doWrite(input logic [6:0] a, input logic [7:0] d);
    logic [7:0] rd;
    applyStimulus({1'b0, a, d}, 16, rd);
    endFrame();
    model_write(int'(a), d);
  endtask

  task automatic doRead(input logic [6:0] a, output logic [7:0] rd);
    applyStimulus({1'b1, a, 8'h00}, 16, rd);
    endFrame();
  endtask

  initial begin
    logic [7:0]  rd;
    logic [6:0]  ra;
    logic [7:0]  rdat;
    logic        rrw;
    int unsigned r;

    rst_n = 1'b0;
    sclk  = 1'b0;
    cs_n  = 1'b1;
    mosi  = 1'b0;
    model_reset();
    wait_clks(3);
    checkAll("reset_held");
    rst_n = 1'b1;
    wait_clks(6);
    checkAll("reset_released");

    doRead(7'h7F, rd);
    checkOutput("read_id", 32'(rd), READBACK ? 32'(8'hCD) : 32'(0));

    $display("[TB] single-byte write timing on adsr_s");
    applyStimulus({1'b0, 7'h03, 8'hC0}, 16, rd);
    wait_clks(3);
    checkOutput("adsr_s_before_commit", 32'(adsr_s), 32'(8'h80));
    wait_clks(1);
    checkOutput("adsr_s_at_commit", 32'(adsr_s), 32'(8'hC0));
    endFrame();
    model_write(3, 8'hC0);
    checkAll("after_adsr_s");

    $display("[TB] staged osc_count update");
    doWrite(7'h05, 8'h11);
    doWrite(7'h06, 8'h22);
    doWrite(7'h07, 8'h33);
    checkOutput("osc_staged", osc_count, 32'h0000_005A);
    applyStimulus({1'b0, 7'h08, 8'h44}, 16, rd);
    wait_clks(3);
    checkOutput("osc_before_commit", osc_count, 32'h0000_005A);
    wait_clks(1);
    checkOutput("osc_at_commit", osc_count, 32'h4433_2211);
    endFrame();
    model_write(8, 8'h44);
    checkAll("after_osc");

    $display("[TB] aborted frame then full frame");
    applyStimulus({1'b0, 7'h01, 8'hA5}, 12, rd);
    endFrame();
    checkOutput("partial_adsr_ai", 32'(adsr_ai), 32'(8'h08));
    doWrite(7'h01, 8'h3C);
    checkOutput("full_adsr_ai", 32'(adsr_ai), 32'(8'h3C));
    checkAll("after_partial");

    $display("[TB] trig pulse");
    doWrite(7'h00, 8'h01);
    checkOutput("trig_high", 32'(trig), 32'(1));
    doWrite(7'h00, 8'h00);
    checkOutput("trig_low", 32'(trig), 32'(0));

    doWrite(7'h0A, 8'h12);
    checkOutput("filter_a_commit", 32'(filter_a), 32'(16'h1200));
    doRead(7'h0A, rd);
    checkOutput("read_filter_a_hi", 32'(rd), READBACK ? 32'(8'h12) : 32'(0));
    doWrite(7'h09, 8'h77);
    doRead(7'h09, rd);
    checkOutput("read_shadow_not_visible", 32'(rd), READBACK ? 32'(8'h00) : 32'(0));

    $display("[TB] randomized frames");
    for (int n = 0; n < 40; n++) begin
      r = $urandom_range(0, 15);
      if (r <= 12)      ra = 7'(r);
      else if (r == 13) ra = 7'h7F;
      else              ra = 7'($urandom_range(13, 126));
      rdat = 8'($urandom);
      rrw  = 1'($urandom_range(0, 1));
      if (rrw) begin
        doRead(ra, rd);
        checkOutput($sformatf("rand_read_%0d_a%02h", n, ra), 32'(rd),
                    READBACK ? 32'(model_read(int'(ra))) : 32'(0));
      end else begin
        doWrite(ra, rdat);
      end
      checkAll($sformatf("rand_%0d", n));
    end

    $display("[TB] reset in the middle of a data phase");
    rd = 8'h00;
    applyStimulus({1'b0, 7'h02, 8'h55}, 11, rd);
    wait_clks(4);
    rst_n = 1'b0;
    #1;
    model_reset();
    checkAll("mid_frame_reset");
    wait_clks(3);
    rst_n = 1'b1;
    shiftBits({1'b0, 7'h02, 8'h55}, 11, 15, rd);
    endFrame();
    checkAll("after_reset_tail");
    doWrite(7'h02, 8'h55);
    checkOutput("post_reset_write", 32'(adsr_di), 32'(8'h55));
    checkAll("final");

    $display("End of test - %0d assertions evaluated, %0d failures", assert_count, fail_count);
    $finish;
  end

endmodule
